fc_layer_par: RTL
=================

Name: fc_layer_par

Overview:
Parametrised fully-connected layer engine for the quantized CIFAR-10 serial pipeline. It is the successor to the single-lane, 1-output-per-pass FC layer.
- Loads weights once via the DMA engineer (wide words) and keeps them resident across images.
- Buffers a C_IN-element input blob, then computes C_OUT outputs KPF lanes at a time with optional ReLU and output saturation.
- Streams results serially on the blob output interface with backpressure.

Parameters:
C_IN, 64, input channels (beats per input blob)
C_OUT, 10, output channels; C_OUT % KPF == 0
KPF, 2, parallel MAC lanes (outputs computed per group)
WW, 4, signed weight width
BW, 8, signed bias width
DIN_DW, 16, signed input width
DOUT_DW, 16, signed output width
ACC_WIDTH, 40, accumulator width
W_Q, 5, arithmetic right shift applied to the accumulator
B_SHIFT, 5, left shift applied to bias before the add
RELU, 0, 1 = clamp negative results to 0
DMA_DW, 512, DMA word width; DMA_DW % (KPF*WW) == 0
START_ADDR, 1824, DMA start address
BIAS_INIT, 0, flattened C_OUT*BW bias constant; bias k at bits [k*BW +: BW]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dma_engineer_req  out  1  weight fetch request
dma_engineer_ack  in  1  request accepted
dma_engineer_start_addr  out  27  = START_ADDR
dma_engineer_length  out  27  = W_WORDS = ceil(C_IN*C_OUT*WW/DMA_DW)
dma_engineer_dout  in  DMA_DW  weight word
dma_engineer_dout_en  in  1  weight word valid
dma_engineer_dout_eop  in  1  last weight word
blob_din  in  DIN_DW  input element
blob_din_en  in  1  input valid
blob_din_eop  in  1  last input element
blob_din_rdy  out  1  ready for input
blob_dout  out  DOUT_DW  result
blob_dout_en  out  1  result valid (one-cycle pulse per element)
blob_dout_eop  out  1  last result
blob_dout_rdy  in  1  downstream ready
err  out  1  sticky framing error

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high. On reset, every output is 0 except start_addr and length, which are constants. FSM goes to LOAD_W and the weights_valid flag clears.
- FSM states: LOAD_W -> IN -> COMP -> OUT -> IN. LOAD_W is entered only after reset.
- LOAD_W:
  - req rises the cycle after reset release and holds until ack is sampled high; it is 0 from the next cycle.
  - Each dout_en word is written to weight RAM (depth W_WORDS) at an incrementing address.
  - The state exits when W_WORDS words have been received.
  - err is set if eop is seen on a word other than the last, or is missing on the last.
- Weight layout: linear index n = (g*C_IN + c)*KPF + p, where g is the group, c the channel and p the lane. Each read selects a KPF*WW slice: word n*WW/DMA_DW, offset by the in-word position.
- IN:
  - blob_din_rdy = 1. Each en beat writes the input buffer at addresses 0..C_IN-1.
  - The state ends on the C_IN-th beat. rdy drops the following cycle.
  - eop on a beat other than C_IN-1, or missing on C_IN-1, sets err. The beat count alone governs termination.
- COMP: for g = 0..C_OUT/KPF-1:
  - Read input and weight slice for c = 0..C_IN-1, one per cycle.
  - Lane product = signed din * sign-extended weight. Accumulate in ACC_WIDTH; the accumulator clears at the start of each group.
  - After the last c: res = (acc + (sext(bias[g*KPF+p]) <<< B_SHIFT)) >>> W_Q, arithmetic shift with truncation.
  - Saturate res to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1]. If RELU, negatives become 0.
  - Write KPF results to the output buffer at index g*KPF+p.
  - Pipeline: RAM read 1 cycle, product register 1, accumulate 1. Each group takes exactly C_IN+3 cycles, and groups are back-to-back.
- OUT:
  - In each cycle with blob_dout_rdy = 1, emit the next element k = 0..C_OUT-1: blob_dout_en = 1 and blob_dout = result k.
  - blob_dout_eop = 1 with k = C_OUT-1.
  - rdy = 0 stalls with en = 0. No element is dropped or repeated.
  - After the last element, go to IN.
- Weights are reused for every subsequent image. req is never reasserted without reset.
- blob_din_rdy is 0 outside IN. Input en while rdy = 0 is ignored.
- Reset mid-operation aborts all state. Weights are reloaded after release.

Test Plan:
1. Reset -> all outputs 0, length = 5 (64*10*4/512). Release -> req = 1 until ack, start_addr = 1824.
2. Load 5 words of 0x11..1 (all weights +1), BIAS_INIT = 0, 64 inputs of 32 -> acc 2048, >>>5 = 64. Ten en pulses of 64, eop on the 10th.
3. Weights 4'h7, inputs 16'h7FFF -> all outputs 16'h7FFF (saturated). Weights 4'h8 -> 16'h8000 with RELU=0, and 0 with RELU=1.
4. Case 2 with bias k = k: each result is 64 + k (bias <<< 5 >>> 5). Checks that bias is indexed per lane.
5. blob_dout_rdy alternating 1/0 -> exactly 10 pulses in order k = 0..9. A second image is accepted with no new req. eop on input beat 10 sets err while output remains correct.
6. Assert rst mid-COMP -> outputs 0 immediately. After release, req = 1 again, and a full reload plus image gives the expected results from case 2.

Source files
------------

// File: rtl/fc_layer_par_if.sv
// fc_layer_par_if: bundle of the DMA weight-fetch and blob stream signals of
// the fully-connected layer engine.
//   master : the engine (drives req/start_addr/length, blob_din_rdy,
//            blob_dout*, err, fsm_state)
//   slave  : the surrounding system (DMA engineer, upstream producer and
//            downstream consumer)
// Handshakes:
//   dma_engineer_req is held high until it is sampled together with
//   dma_engineer_ack. A weight word moves on every cycle with
//   dma_engineer_dout_en = 1. An input element moves on a cycle with
//   blob_din_en = 1 and blob_din_rdy = 1, and blob_din_en is ignored while
//   blob_din_rdy = 0. An output element moves on a cycle with blob_dout_en = 1,
//   which only happens while blob_dout_rdy = 1. The *_eop flags mark the last
//   beat of each transfer.
// fsm_state is a debug copy of the engine's control state.
interface fc_layer_par_if #(
   parameter int DMA_DW  = 512,
   parameter int DIN_DW  = 16,
   parameter int DOUT_DW = 16
);
   logic               dma_engineer_req;
   logic               dma_engineer_ack;
   logic [26:0]        dma_engineer_start_addr;
   logic [26:0]        dma_engineer_length;
   logic [DMA_DW-1:0]  dma_engineer_dout;
   logic               dma_engineer_dout_en;
   logic               dma_engineer_dout_eop;
   logic [DIN_DW-1:0]  blob_din;
   logic               blob_din_en;
   logic               blob_din_eop;
   logic               blob_din_rdy;
   logic [DOUT_DW-1:0] blob_dout;
   logic               blob_dout_en;
   logic               blob_dout_eop;
   logic               blob_dout_rdy;
   logic               err;
   logic [1:0]         fsm_state;

   modport master (
      output dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
      input  dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en, dma_engineer_dout_eop,
      input  blob_din, blob_din_en, blob_din_eop,
      output blob_din_rdy,
      output blob_dout, blob_dout_en, blob_dout_eop,
      input  blob_dout_rdy,
      output err, fsm_state
   );

   modport slave (
      input  dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
      output dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en, dma_engineer_dout_eop,
      output blob_din, blob_din_en, blob_din_eop,
      input  blob_din_rdy,
      input  blob_dout, blob_dout_en, blob_dout_eop,
      output blob_dout_rdy,
      input  err, fsm_state
   );
endinterface

// File: rtl/fc_layer_par.sv
// fc_layer_par: fully-connected layer engine with KPF parallel MAC lanes.
// Weights are fetched once after reset through the DMA engineer and stay
// resident. Each image is buffered (C_IN elements), then C_OUT outputs are
// computed KPF at a time (bias, shift, saturation, optional ReLU) and streamed
// out serially with backpressure.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - fc_layer_par_if.master: DMA request/weight words, input blob
//          stream, output blob stream, sticky framing error, debug state
module fc_layer_par #(
   parameter int C_IN      = 64,
   parameter int C_OUT     = 10,
   parameter int KPF       = 2,
   parameter int WW        = 4,
   parameter int BW        = 8,
   parameter int DIN_DW    = 16,
   parameter int DOUT_DW   = 16,
   parameter int ACC_WIDTH = 40,
   parameter int W_Q       = 5,
   parameter int B_SHIFT   = 5,
   parameter int RELU      = 0,
   parameter int DMA_DW    = 512,
   parameter int START_ADDR = 1824,
   parameter logic [C_OUT*BW-1:0] BIAS_INIT = '0
) (
   input logic clk,
   input logic rst,
   fc_layer_par_if.master bus
);

   localparam int W_WORDS = (C_IN*C_OUT*WW + DMA_DW - 1) / DMA_DW;
   localparam int GROUPS  = C_OUT / KPF;
   localparam int SLICE   = KPF * WW;
   localparam int SPW     = DMA_DW / SLICE;   // lane slices per DMA word
   localparam int PW      = DIN_DW + WW;
   localparam int IAW     = (C_IN > 1)    ? $clog2(C_IN)    : 1;
   localparam int CW      = $clog2(C_IN + 3);
   localparam int WAW     = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
   localparam int GW      = (GROUPS > 1)  ? $clog2(GROUPS)  : 1;
   localparam int OW      = (C_OUT > 1)   ? $clog2(C_OUT)   : 1;
   localparam int SW      = (SPW > 1)     ? $clog2(SPW)     : 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = (ACC_WIDTH'(1) <<< (DOUT_DW-1)) - 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -(ACC_WIDTH'(1) <<< (DOUT_DW-1));

   typedef enum logic [1:0] {LOAD_W = 2'd0, IN = 2'd1, COMP = 2'd2, OUT = 2'd3} state_t;
   state_t state_q, state_d;

   // storage
   logic [DMA_DW-1:0]        wram [W_WORDS];
   logic signed [DIN_DW-1:0] ibuf [C_IN];
   logic signed [DOUT_DW-1:0] obuf [C_OUT];

   // control
   logic           req_q, req_done, weights_valid, err_q;
   logic [WAW-1:0] wcnt;
   logic [IAW-1:0] in_cnt;
   logic [CW-1:0]  cyc;
   logic [GW-1:0]  grp;
   logic [OW-1:0]  out_idx;
   logic [WAW-1:0] rd_word;
   logic [SW-1:0]  rd_slot;
   logic           v1, first1, v2, first2;

   // datapath
   logic signed [DIN_DW-1:0]    din_rd;
   logic [SLICE-1:0]            w_rd;
   logic signed [PW-1:0]        prod [KPF];
   logic signed [ACC_WIDTH-1:0] acc  [KPF];

   logic din_rdy, load_beat, last_word, in_beat, last_in;
   logic issue, grp_end, last_grp, out_fire, last_out;

   assign din_rdy   = (state_q == IN) && weights_valid;
   assign load_beat = (state_q == LOAD_W) && bus.dma_engineer_dout_en;
   assign last_word = (wcnt == WAW'(W_WORDS-1));
   assign in_beat   = din_rdy && bus.blob_din_en;
   assign last_in   = (in_cnt == IAW'(C_IN-1));
   assign issue     = (state_q == COMP) && (cyc < CW'(C_IN));
   // Last cycle of a group: the accumulator holds the full sum for every lane.
   assign grp_end   = (state_q == COMP) && (cyc == CW'(C_IN+2));
   assign last_grp  = (grp == GW'(GROUPS-1));
   assign out_fire  = (state_q == OUT) && bus.blob_dout_rdy;
   assign last_out  = (out_idx == OW'(C_OUT-1));

   // Bias add, arithmetic shift, saturation and optional ReLU for one lane.
   function automatic logic signed [DOUT_DW-1:0] sat_res(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic signed [BW-1:0]        b
   );
      logic signed [ACC_WIDTH-1:0] s;
      s = (a + (ACC_WIDTH'(b) <<< B_SHIFT)) >>> W_Q;
      if (RELU != 0 && s < 0) return '0;
      if (s > SAT_HI) return DOUT_DW'(SAT_HI);
      if (s < SAT_LO) return DOUT_DW'(SAT_LO);
      return DOUT_DW'(s);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LOAD_W;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      bus.dma_engineer_req        = req_q;
      bus.dma_engineer_start_addr = 27'(START_ADDR);
      bus.dma_engineer_length     = 27'(W_WORDS);
      bus.blob_din_rdy            = din_rdy;
      bus.blob_dout_en            = out_fire;
      bus.blob_dout               = out_fire ? obuf[out_idx] : '0;
      bus.blob_dout_eop           = out_fire && last_out;
      bus.err                     = err_q;
      bus.fsm_state               = state_q;
      unique case (state_q)
         LOAD_W:  if (load_beat && last_word) state_d = IN;
         IN:      if (in_beat && last_in)     state_d = COMP;
         COMP:    if (grp_end && last_grp)    state_d = OUT;
         OUT:     if (out_fire && last_out)   state_d = IN;
         default: state_d = LOAD_W;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q         <= 1'b0;
         req_done      <= 1'b0;
         weights_valid <= 1'b0;
         err_q         <= 1'b0;
         wcnt          <= '0;
         in_cnt        <= '0;
         cyc           <= '0;
         grp           <= '0;
         out_idx       <= '0;
         rd_word       <= '0;
         rd_slot       <= '0;
         v1            <= 1'b0;
         first1        <= 1'b0;
         v2            <= 1'b0;
         first2        <= 1'b0;
      end else begin
         // One request per reset: raise, hold until acked, never again.
         if (state_q != LOAD_W) begin
            req_q <= 1'b0;
         end else if (!req_done) begin
            if (!req_q) begin
               req_q <= 1'b1;
            end else if (bus.dma_engineer_ack) begin
               req_q    <= 1'b0;
               req_done <= 1'b1;
            end
         end

         if (load_beat) begin
            if (bus.dma_engineer_dout_eop != last_word) err_q <= 1'b1;
            wcnt <= wcnt + 1'b1;
            if (last_word) weights_valid <= 1'b1;
         end

         if (in_beat) begin
            if (bus.blob_din_eop != last_in) err_q <= 1'b1;
            in_cnt <= last_in ? '0 : in_cnt + 1'b1;
         end

         if (state_q == IN) begin
            cyc     <= '0;
            grp     <= '0;
            rd_word <= '0;
            rd_slot <= '0;
         end

         if (state_q == COMP) begin
            cyc <= grp_end ? '0 : cyc + 1'b1;
            if (grp_end) grp <= last_grp ? '0 : grp + 1'b1;
         end

         // Slices are consumed in linear order across groups, so a running
         // word/slot pointer replaces the index multiply.
         if (issue) begin
            if (rd_slot == SW'(SPW-1)) begin
               rd_slot <= '0;
               rd_word <= rd_word + 1'b1;
            end else begin
               rd_slot <= rd_slot + 1'b1;
            end
         end

         v1     <= issue;
         first1 <= issue && (cyc == '0);
         v2     <= v1;
         first2 <= first1;

         if (out_fire) out_idx <= last_out ? '0 : out_idx + 1'b1;
      end
   end

   // Storage and MAC pipeline: read (1) -> product (1) -> accumulate (1).
   always_ff @(posedge clk) begin
      if (load_beat) wram[wcnt] <= bus.dma_engineer_dout;
      if (in_beat)   ibuf[in_cnt] <= bus.blob_din;
      if (issue) begin
         din_rd <= ibuf[cyc[IAW-1:0]];
         w_rd   <= wram[rd_word][rd_slot*SLICE +: SLICE];
      end
      for (int p = 0; p < KPF; p++) begin
         prod[p] <= PW'(din_rd) * PW'($signed(w_rd[p*WW +: WW]));
         if (v2) acc[p] <= first2 ? ACC_WIDTH'(prod[p]) : acc[p] + ACC_WIDTH'(prod[p]);
         if (grp_end)
            obuf[OW'(grp*KPF + p)] <= sat_res(acc[p], BIAS_INIT[(grp*KPF + p)*BW +: BW]);
      end
   end

endmodule
